// File: rtl/mac_pkg.sv
// Shared types and constants for the time-multiplexed multiply-accumulate sequencer.
package mac_pkg;

  // Sequencer states: waiting for a vector, stepping through terms, holding the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_W    = 8;
  localparam int DEFAULT_NUM_TERMS = 3;
  localparam int DEFAULT_ACC_W     = 24;

  // Width of the term index; a single-term vector still needs a one-bit counter.
  function automatic int idx_width(input int num_terms);
    return (num_terms > 1) ? $clog2(num_terms) : 1;
  endfunction

  // Smallest accumulator that can hold NUM_TERMS full-scale products without wrapping.
  function automatic int min_acc_width(input int data_w, input int num_terms);
    return 2 * data_w + $clog2(num_terms);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Single shared unsigned multiplier feeding the accumulator adder.
module mac_unit
  import mac_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ACC_W-1:0]  acc_i,
  output logic [ACC_W-1:0]  sum_o
);

  logic [2*DATA_W-1:0] product;

  // Full-width product, zero-extended into the accumulator and added.
  always_comb begin
    product = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    sum_o   = acc_i + ACC_W'(product);
  end

endmodule

// File: rtl/mac_sequencer.sv
// Multiply-accumulate controller: captures an operand vector, feeds one term per
// cycle through a single shared multiplier, and returns the sum over a handshake.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_TERMS = DEFAULT_NUM_TERMS,
  parameter int ACC_W     = DEFAULT_ACC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_TERMS*DATA_W-1:0] a_vec,
  input  logic [NUM_TERMS*DATA_W-1:0] b_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            result,
  output logic                        busy
);

  localparam int IDX_W = idx_width(NUM_TERMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TERMS - 1);

  // Reject configurations that could overflow or have nothing to sequence.
  if (NUM_TERMS < 1) begin : g_bad_terms
    $error("mac_sequencer: NUM_TERMS must be at least 1");
  end
  if (ACC_W < min_acc_width(DATA_W, NUM_TERMS)) begin : g_bad_acc
    $error("mac_sequencer: ACC_W too narrow for DATA_W and NUM_TERMS");
  end

  state_e                      state_q;
  logic [IDX_W-1:0]            idx_q;
  logic [ACC_W-1:0]            acc_q;
  logic [NUM_TERMS*DATA_W-1:0] a_q;
  logic [NUM_TERMS*DATA_W-1:0] b_q;

  logic [DATA_W-1:0] a_cur;
  logic [DATA_W-1:0] b_cur;
  logic [ACC_W-1:0]  acc_d;

  // Current term selected from the captured operands by the index counter.
  always_comb begin
    a_cur = a_q[int'(idx_q)*DATA_W +: DATA_W];
    b_cur = b_q[int'(idx_q)*DATA_W +: DATA_W];
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac_unit (
    .a_i   (a_cur),
    .b_i   (b_cur),
    .acc_i (acc_q),
    .sum_o (acc_d)
  );

  // Sequencer FSM: capture in IDLE, accumulate one term per cycle in RUN, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a_vec;
            b_q     <= b_vec;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          // acc_q is left alone so the result stays visible until the next capture.
          if (out_ready) begin
            idx_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags come straight from the state register, never from the inputs.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    result    = acc_q;
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a result scoreboard.
module tb_mac_sequencer;

  localparam int DATA_W    = 8;
  localparam int NUM_TERMS = 3;
  localparam int ACC_W     = 24;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_TERMS*DATA_W-1:0] a_vec;
  logic [NUM_TERMS*DATA_W-1:0] b_vec;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_W-1:0]            result;
  logic                        busy;

  int          checks   = 0;
  int          failures = 0;
  int          txn      = 0;
  int unsigned sb[$];

  mac_sequencer #(
    .DATA_W    (DATA_W),
    .NUM_TERMS (NUM_TERMS),
    .ACC_W     (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a vector, wait for acceptance, record the expected sum.
  task automatic send(input logic [23:0] a, input logic [23:0] b, input int unsigned exp);
    int n = 0;
    a_vec    = a;
    b_vec    = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(exp);
    a_vec = 24'($urandom);
    b_vec = 24'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  // Accept one result and compare it against the oldest scoreboard entry.
  task automatic receive();
    int n = 0;
    int unsigned exp;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      check("result", 32'(result), exp);
      txn++;
      $display("txn %0d result=0x%06h expected=0x%06h", txn, result, exp);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_vec     = '0;
    b_vec     = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic vector with latency check: out_valid rises after the third edge.
    send({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 32);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("latency_out_valid_low", 32'(out_valid), 32'd0);
      check("latency_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("latency_out_valid_high", 32'(out_valid), 32'd1);
    receive();

    // All operands at full scale.
    send({8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255}, 195075);
    receive();

    // Backpressure: result must hold steady while out_ready is low.
    send({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 32);
    begin
      int n = 0;
      while (out_valid !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'd32);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    receive();

    // in_valid while busy is ignored; the pending vector is taken only back in IDLE.
    send({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 32);
    a_vec    = {8'd9, 8'd9, 8'd9};
    b_vec    = {8'd9, 8'd9, 8'd9};
    in_valid = 1'b1;
    receive();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(243);
    check("second_capture_busy", 32'(busy), 32'd1);
    receive();
    @(negedge clk);
    check("single_capture_idle", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of RUN discards the transaction.
    send({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 32);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_result", 32'(result), 32'd0);
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold_out_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    send({8'd0, 8'd0, 8'd2}, {8'd0, 8'd0, 8'd7}, 14);
    receive();

    // Asynchronous reset while a result is pending in DONE.
    send({8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2}, 6);
    begin
      int n = 0;
      while (out_valid !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    check("done_pending_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("done_rst_out_valid", 32'(out_valid), 32'd0);
    check("done_rst_result", 32'(result), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    send({8'd10, 8'd20, 8'd30}, {8'd1, 8'd2, 8'd3}, 140);
    receive();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Time-multiplexed multiply-accumulate controller. It accepts a vector of NUM_TERMS operand pairs over a valid/ready handshake and drives one shared DATA_W x DATA_W multiplier, one term per cycle. It accumulates the products and returns the sum over a second valid/ready handshake. It replaces per-term parallel multipliers in the benchmark datapath, trading latency for multiplier area.

Parameters:
DATA_W, 8, operand width (unsigned)
NUM_TERMS, 3, operand pairs per transaction (>=1)
ACC_W, 24, result width; must satisfy ACC_W >= 2*DATA_W + clog2(NUM_TERMS), elaboration error otherwise

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand vector valid
in_ready  out  1  block can accept a vector
a_vec  in  NUM_TERMS*DATA_W  operands A; term i at bits [i*DATA_W +: DATA_W]
b_vec  in  NUM_TERMS*DATA_W  operands B, same packing
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  ACC_W  sum over i of a_i*b_i, unsigned
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, idx=0, acc=0, operand regs=0. in_ready=1, out_valid=0, result=0, busy=0.
- States: IDLE, RUN, DONE. Encoding in package.
- IDLE: in_ready=1. On edge with in_valid&in_ready: capture a_vec/b_vec into internal regs, acc<=0, idx<=0, go to RUN. Otherwise hold.
- RUN: in_ready=0, busy=1. Each cycle: product = a_reg[idx]*b_reg[idx], 2*DATA_W bits, zero-extended to ACC_W. acc<=acc+product. If idx==NUM_TERMS-1, go to DONE; else idx<=idx+1.
- DONE: out_valid=1, result=acc, held stable until out_ready. On edge with out_ready: go to IDLE, idx<=0. acc keeps its value until the next capture.
- Latency: vector accepted at edge k; out_valid first high after edge k+NUM_TERMS. NUM_TERMS=3 gives 3 cycles.
- Throughput: one transaction per NUM_TERMS+2 cycles minimum (IDLE, RUN x N, DONE). No overlap: in_ready is low in RUN and DONE, even when out_ready=1.
- in_valid while busy is ignored. Input vectors may change freely after capture. a_vec/b_vec are sampled only at the accept edge.
- out_valid/result must not change while out_valid=1 and out_ready=0.
- out_ready while not in DONE has no effect.
- NUM_TERMS=1: RUN lasts exactly one cycle.
- Arithmetic: unsigned, no saturation. The ACC_W constraint guarantees no overflow.
- Async reset at any point, including mid-RUN or in DONE with a pending result: the transaction is discarded and all outputs return immediately to reset values. No partial result is ever emitted.
- in_ready, out_valid and busy decode directly from state. No combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package mac_pkg: state enum (IDLE/RUN/DONE), default width constants, IDX_W = clog2(NUM_TERMS) helper.
- One sub-module, mac_unit: combinational DATA_W x DATA_W unsigned multiply plus ACC_W adder. Keeps the shared multiplier a single instance so synthesis maps it to one DSP/LUT multiplier.
- Sequencer FSM, idx counter and operand registers stay in the top.

Test Plan:
- Reset: hold rst high 3 cycles -> in_ready=1, out_valid=0, busy=0, result=0. Assert rst async mid-cycle -> outputs change before the next clk edge.
- Basic: A=(1,2,3), B=(4,5,6), out_ready=1 -> out_valid high 3 cycles after accept, result=32 (0x000020). in_ready returns high the cycle after out handshake.
- Max: all operands 255, NUM_TERMS=3 -> result=195075 (0x02FA03), no overflow.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1 and result=32 stable all 5 cycles, in_ready=0. Raise out_ready -> IDLE next cycle.
- Busy ignore: during RUN drive in_valid=1 with A=B=(9,9,9) -> no capture, first result unaffected. Vector accepted only once back in IDLE, giving result 243.
- Reset mid-RUN: accept A=(1,2,3),B=(4,5,6), assert rst after idx=1 -> no out_valid. After release, a new A=(2,0,0),B=(7,0,0) -> result=14.
